fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage directly upstream of imm_generator. Owns the PC and issues one
//  instruction-memory read at a time. Holds the returned word in an IF/ID register with a
//  valid/ready handshake to decode. Computes the branch redirect target as
//  if_pc + (branch_imm << 1), where branch_imm is the gen_out value fed back from decode.
// PARAMETERS
//  XLEN      32     datapath / address width
//  RESET_PC  32'h0  first fetch address after reset
// PORTS
//  clk           in   1     single clock; all state changes on posedge
//  rst_n         in   1     reset, asynchronous, active-low
//  imem_req      out  1     read request; registered; one outstanding max
//  imem_addr     out  XLEN  word-aligned read address; stable while imem_req=1
//  imem_gnt      in   1     memory accepted request this cycle (imem_req & imem_gnt)
//  imem_rvalid   in   1     read data valid; >=1 cycle after grant
//  imem_rdata    in   32    instruction word
//  if_valid      out  1     IF/ID register holds a live instruction
//  if_inst       out  32    instruction to decode / imm_generator
//  if_pc         out  XLEN  PC of if_inst
//  id_ready      in   1     decode consumes if_inst when if_valid & id_ready
//  branch_taken  in   1     redirect; qualified by if_valid; refers to the current if_pc
//  branch_imm    in   XLEN  sign-extended immediate (gen_out) of the branch in decode
// BEHAVIOUR
//  Reset (async assert, sync release): pc=RESET_PC, imem_req=0, imem_addr=RESET_PC,
//   if_valid=0, if_inst=32'h0000_0013 (NOP), if_pc=RESET_PC, state=ISSUE.
//  First posedge after release: imem_req=1, imem_addr=RESET_PC.
//  States:
//   ISSUE: drive req at pc. On gnt -> WAIT, pc<=pc+4.
//   WAIT: await rvalid. On rvalid: if IF/ID is empty or being consumed this cycle, load
//    it and go to ISSUE. Otherwise go to FULL and buffer the word in a 1-entry skid.
//   FULL: skid holds the word. On consume, move skid to IF/ID -> ISSUE.
//   DISCARD: the outstanding response is stale. On rvalid, drop the data -> ISSUE.
//  Best case is one instruction every 2 cycles (req/gnt, then rvalid); no prefetch beyond 1.
//  imem_req deasserts the cycle after gnt. imem_addr may change only when imem_req=0 or
//   on gnt.
//  Redirect (branch_taken & if_valid), highest priority:
//   target = if_pc + {branch_imm[XLEN-2:0],1'b0}; mod 2^XLEN, wrap-around allowed.
//   pc<=target; if_valid<=0 next cycle; skid cleared.
//   If a request is in WAIT, or granted this cycle -> DISCARD; else -> ISSUE.
//   branch_taken with if_valid=0 is ignored. A redirect coinciding with rvalid drops
//    that word.
//  Stall: if_valid=1 & id_ready=0 -> if_inst/if_pc hold; at most one further fetch is
//   completed (into the skid); no new req is issued while in FULL.
//  Simultaneous consume+rvalid in WAIT: new word loads straight into IF/ID, no bubble.
//  Reset mid-operation: all state returns to reset values immediately; any in-flight
//   response after release is ignored until the first new gnt (state ISSUE, req=0 until
//   the first posedge).
//  Misaligned target (bit1 set, no C ext): fetched as-is; trapping is out of scope.
// STRUCTURE
//  riscv_pkg: XLEN, RESET_PC default, NOP encoding 32'h0000_0013, fetch state encoding
//   (ISSUE, WAIT, FULL, DISCARD).
//  Sub-module branch_target_adder: shifts branch_imm left by 1 and adds if_pc;
//   combinational.
//  Top: PC register, FSM, IF/ID register plus 1-entry skid.
// TESTING
//  1. Reset release, gnt same cycle, rvalid next cycle with id_ready=1 -> fetches 0x0,0x4,0x8;
//     if_pc matches; 2-cycle cadence.
//  2. id_ready=0 for 5 cycles with if_pc=0x4 -> if_inst holds; one word buffered at 0x8;
//     no req; release -> 0x8 presented next cycle.
//  3. branch_taken with if_pc=0x10, branch_imm=0xFFFF_FFF8 -> next req at 0x0; stale
//     rvalid dropped; if_valid=0 until the 0x0 word arrives.
//  4. branch_taken on the same cycle as rvalid -> word dropped; req at target; no stale
//     instruction reaches decode.
//  5. rst_n asserted in WAIT -> outputs at reset values immediately; late rvalid ignored;
//     refetch from RESET_PC.
//  6. if_pc=0xFFFF_FFF0, branch_imm=0x10 -> target 0x0000_0010 (wrap-around).

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants and the fetch-stage state encoding for the front end.
package riscv_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_ISSUE   = 2'd0,
    FS_WAIT    = 2'd1,
    FS_FULL    = 2'd2,
    FS_DISCARD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_branch_target_adder.sv
// Branch redirect target: pc plus the half-word-scaled immediate, wrapping mod 2^XLEN.
module branch_target_adder #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  output logic [XLEN-1:0] target_o
);

  logic [XLEN-1:0] imm_shl_s;

  // Shift out the immediate MSB and add; carry out of XLEN is discarded.
  always_comb begin
    imm_shl_s = imm_i << 1'b1;
    target_o  = pc_i + imm_shl_s;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, single-outstanding imem request FSM, IF/ID register with a 1-entry skid.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  output logic [31:0]     if_inst,
  output logic [XLEN-1:0] if_pc,
  input  logic            id_ready,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_imm
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

  fetch_state_e    state_q, state_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            if_valid_q, if_valid_d;
  logic [31:0]     if_inst_q, if_inst_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [31:0]     skid_inst_q, skid_inst_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [XLEN-1:0] target_s;

  logic gnt_s, redirect_s, consume_s, rsp_direct_s, rsp_skid_s, skid_drain_s, outstanding_s;

  assign gnt_s        = req_q & imem_gnt;
  assign redirect_s   = branch_taken & if_valid_q;
  assign consume_s    = if_valid_q & id_ready;
  assign rsp_direct_s = (state_q == FS_WAIT) & imem_rvalid & (~if_valid_q | consume_s);
  assign rsp_skid_s   = (state_q == FS_WAIT) & imem_rvalid & if_valid_q & ~consume_s;
  assign skid_drain_s = (state_q == FS_FULL) & consume_s;
  // A response still owed by memory after this edge must be swallowed on redirect.
  assign outstanding_s = ((state_q == FS_WAIT) & ~imem_rvalid) |
                         ((state_q == FS_DISCARD) & ~imem_rvalid) |
                         ((state_q == FS_ISSUE) & gnt_s);

  branch_target_adder #(.XLEN(XLEN)) u_target (
    .pc_i     (if_pc_q),
    .imm_i    (branch_imm),
    .target_o (target_s)
  );

  // State, PC and IF/ID registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FS_ISSUE;
      req_q       <= 1'b0;
      pc_q        <= RESET_PC;
      fetch_pc_q  <= RESET_PC;
      if_valid_q  <= 1'b0;
      if_inst_q   <= NOP_INST;
      if_pc_q     <= RESET_PC;
      skid_inst_q <= NOP_INST;
      skid_pc_q   <= RESET_PC;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      pc_q        <= pc_d;
      fetch_pc_q  <= fetch_pc_d;
      if_valid_q  <= if_valid_d;
      if_inst_q   <= if_inst_d;
      if_pc_q     <= if_pc_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
    end
  end

  // Next-state logic; redirect overrides the normal flow.
  always_comb begin
    state_d = state_q;
    if (redirect_s) begin
      state_d = outstanding_s ? FS_DISCARD : FS_ISSUE;
    end else begin
      case (state_q)
        FS_ISSUE:   state_d = gnt_s ? FS_WAIT : FS_ISSUE;
        FS_WAIT:    state_d = imem_rvalid ? (rsp_skid_s ? FS_FULL : FS_ISSUE) : FS_WAIT;
        FS_FULL:    state_d = consume_s ? FS_ISSUE : FS_FULL;
        FS_DISCARD: state_d = imem_rvalid ? FS_ISSUE : FS_DISCARD;
        default:    state_d = FS_ISSUE;
      endcase
    end
  end

  // Request, PC and IF/ID/skid next values.
  always_comb begin
    // Redirect drops req for one cycle so imem_addr never moves under a live request.
    req_d       = (state_d == FS_ISSUE) & ~redirect_s;
    pc_d        = pc_q;
    fetch_pc_d  = fetch_pc_q;
    if_valid_d  = if_valid_q;
    if_inst_d   = if_inst_q;
    if_pc_d     = if_pc_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
    if (gnt_s) begin
      fetch_pc_d = pc_q;
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
    if (redirect_s) begin
      pc_d       = target_s;
      if_valid_d = 1'b0;
    end else begin
      if (gnt_s) begin
        pc_d = pc_q + PC_STEP;
      end else begin
        pc_d = pc_q;
      end
      if (rsp_direct_s) begin
        if_valid_d = 1'b1;
        if_inst_d  = imem_rdata;
        if_pc_d    = fetch_pc_q;
      end else if (rsp_skid_s) begin
        skid_inst_d = imem_rdata;
        skid_pc_d   = fetch_pc_q;
      end else if (skid_drain_s) begin
        if_valid_d = 1'b1;
        if_inst_d  = skid_inst_q;
        if_pc_d    = skid_pc_q;
      end else if (consume_s) begin
        if_valid_d = 1'b0;
      end else begin
        if_valid_d = if_valid_q;
      end
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_inst   = if_inst_q;
  assign if_pc     = if_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a fixed-latency instruction memory responder.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        branch_taken;
  logic [31:0] branch_imm;

  int          total;
  int          bad;
  int          mem_lat;
  int          mem_cnt;
  logic [31:0] mem_addr;
  logic [31:0] cons_pc[$];

  fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_inst      (if_inst),
    .if_pc        (if_pc),
    .id_ready     (id_ready),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {8'hC0, a[23:0]};
  endfunction

  // Memory: always grants; data returns mem_lat cycles after the grant edge.
  initial begin
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    mem_cnt     = 0;
    mem_addr    = 32'h0;
    forever begin
      @(negedge clk);
      #2;
      imem_rvalid = 1'b0;
      if (mem_cnt > 0) begin
        mem_cnt = mem_cnt - 1;
        if (mem_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(mem_addr);
        end
      end
      if (imem_req && imem_gnt) begin
        mem_addr = imem_addr;
        mem_cnt  = mem_lat;
      end
    end
  end

  // Decode side: log every PC handed over.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && if_valid && id_ready) cons_pc.push_back(if_pc);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_run();
    rst_n        = 1'b0;
    branch_taken = 1'b0;
    branch_imm   = 32'h0;
    id_ready     = 1'b1;
    mem_lat      = 1;
    step(4);
    rst_n = 1'b1;
    cons_pc.delete();
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    branch_taken = 1'b0;
    branch_imm   = 32'h0;
    id_ready     = 1'b1;
    mem_lat      = 1;
    step(2);
    total++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || if_valid !== 1'b0 ||
        if_inst !== 32'h0000_0013 || if_pc !== 32'h0) begin
      bad++;
      $display("FAIL reset_state: req=%b addr=%h valid=%b inst=%h pc=%h, want 0 0 0 00000013 0",
               imem_req, imem_addr, if_valid, if_inst, if_pc);
    end
    rst_n = 1'b1;
    step(1);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL first_req: req=%b addr=%h, want 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_fetch_seq();
    logic [31:0] exp_pc;
    start_run();
    step(2);
    total++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h4 || if_valid !== 1'b0) begin
      bad++;
      $display("FAIL seq_wait: req=%b addr=%h valid=%b, want 0 00000004 0", imem_req, imem_addr, if_valid);
    end
    for (int k = 0; k < 3; k++) begin
      exp_pc = 32'h4 * k;
      step(1);
      total++;
      if (if_valid !== 1'b1 || if_pc !== exp_pc || if_inst !== (32'hC000_0000 | exp_pc)) begin
        bad++;
        $display("FAIL seq_word%0d: valid=%b pc=%h inst=%h, want 1 %h %h",
                 k, if_valid, if_pc, if_inst, exp_pc, 32'hC000_0000 | exp_pc);
      end
      step(1);
      total++;
      if (if_valid !== 1'b0) begin
        bad++;
        $display("FAIL seq_gap%0d: valid=%b, want 0", k, if_valid);
      end
    end
    total++;
    if (cons_pc.size() != 3 || cons_pc[0] !== 32'h0 || cons_pc[1] !== 32'h4 || cons_pc[2] !== 32'h8) begin
      bad++;
      $display("FAIL seq_consumed: count=%0d, want 3 entries 0,4,8", cons_pc.size());
    end
  endtask

  task automatic test_stall();
    start_run();
    step(5);
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'h4) begin
      bad++;
      $display("FAIL stall_pre: valid=%b pc=%h, want 1 00000004", if_valid, if_pc);
    end
    id_ready = 1'b0;
    for (int n = 6; n <= 10; n++) begin
      step(1);
      total++;
      if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_inst !== 32'hC000_0004 || imem_req !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold%0d: valid=%b pc=%h inst=%h req=%b, want 1 00000004 c0000004 0",
                 n, if_valid, if_pc, if_inst, imem_req);
      end
    end
    id_ready = 1'b1;
    step(1);
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_inst !== 32'hC000_0008 ||
        imem_req !== 1'b1 || imem_addr !== 32'hC) begin
      bad++;
      $display("FAIL stall_release: valid=%b pc=%h inst=%h req=%b addr=%h, want 1 00000008 c0000008 1 0000000c",
               if_valid, if_pc, if_inst, imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect();
    start_run();
    step(11);
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'h10 || imem_req !== 1'b1 || imem_addr !== 32'h14) begin
      bad++;
      $display("FAIL redir_pre: valid=%b pc=%h req=%b addr=%h, want 1 00000010 1 00000014",
               if_valid, if_pc, imem_req, imem_addr);
    end
    branch_taken = 1'b1;
    branch_imm   = 32'hFFFF_FFF8;
    step(1);
    branch_taken = 1'b0;
    total++;
    if (if_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL redir_next: valid=%b req=%b addr=%h, want 0 0 00000000", if_valid, imem_req, imem_addr);
    end
    step(1);
    total++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL redir_req: valid=%b req=%b addr=%h, want 0 1 00000000", if_valid, imem_req, imem_addr);
    end
    step(1);
    total++;
    if (if_valid !== 1'b0) begin
      bad++;
      $display("FAIL redir_bubble: valid=%b, want 0", if_valid);
    end
    step(1);
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== 32'hC000_0000) begin
      bad++;
      $display("FAIL redir_target: valid=%b pc=%h inst=%h, want 1 00000000 c0000000", if_valid, if_pc, if_inst);
    end
  endtask

  task automatic test_redirect_rvalid();
    start_run();
    step(3);
    id_ready = 1'b0;
    step(1);
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL rr_wait: valid=%b pc=%h req=%b, want 1 00000000 0", if_valid, if_pc, imem_req);
    end
    branch_taken = 1'b1;
    branch_imm   = 32'h20;
    step(1);
    branch_taken = 1'b0;
    id_ready     = 1'b1;
    total++;
    if (if_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h40) begin
      bad++;
      $display("FAIL rr_drop: valid=%b req=%b addr=%h, want 0 0 00000040", if_valid, imem_req, imem_addr);
    end
    step(1);
    total++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      bad++;
      $display("FAIL rr_req: valid=%b req=%b addr=%h, want 0 1 00000040", if_valid, imem_req, imem_addr);
    end
    step(2);
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_inst !== 32'hC000_0040) begin
      bad++;
      $display("FAIL rr_target: valid=%b pc=%h inst=%h, want 1 00000040 c0000040", if_valid, if_pc, if_inst);
    end
    step(1);
    total++;
    if (cons_pc.size() != 1 || cons_pc[0] !== 32'h40) begin
      bad++;
      $display("FAIL rr_consumed: count=%0d, want exactly one entry 00000040", cons_pc.size());
    end
  endtask

  task automatic test_consume_load();
    start_run();
    step(3);
    id_ready = 1'b0;
    step(1);
    id_ready = 1'b1;
    step(1);
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_inst !== 32'hC000_0004) begin
      bad++;
      $display("FAIL no_bubble: valid=%b pc=%h inst=%h, want 1 00000004 c0000004", if_valid, if_pc, if_inst);
    end
  endtask

  task automatic test_reset_wait();
    start_run();
    mem_lat = 3;
    step(5);
    id_ready = 1'b0;
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
      bad++;
      $display("FAIL rw_pre: valid=%b pc=%h, want 1 00000000", if_valid, if_pc);
    end
    step(1);
    rst_n = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || if_valid !== 1'b0 ||
        if_inst !== 32'h0000_0013 || if_pc !== 32'h0) begin
      bad++;
      $display("FAIL rw_async: req=%b addr=%h valid=%b inst=%h pc=%h, want 0 0 0 00000013 0",
               imem_req, imem_addr, if_valid, if_inst, if_pc);
    end
    step(2);
    rst_n    = 1'b1;
    id_ready = 1'b1;
    step(1);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin
      bad++;
      $display("FAIL rw_refetch: req=%b addr=%h valid=%b, want 1 00000000 0", imem_req, imem_addr, if_valid);
    end
    for (int n = 10; n <= 12; n++) begin
      step(1);
      total++;
      if (if_valid !== 1'b0) begin
        bad++;
        $display("FAIL rw_late%0d: valid=%b pc=%h, want valid 0", n, if_valid, if_pc);
      end
    end
    step(1);
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== 32'hC000_0000) begin
      bad++;
      $display("FAIL rw_word: valid=%b pc=%h inst=%h, want 1 00000000 c0000000", if_valid, if_pc, if_inst);
    end
  endtask

  task automatic test_wrap();
    start_run();
    step(3);
    branch_taken = 1'b1;
    branch_imm   = 32'hFFFF_FFF8;
    step(1);
    branch_taken = 1'b0;
    total++;
    if (imem_addr !== 32'hFFFF_FFF0 || if_valid !== 1'b0) begin
      bad++;
      $display("FAIL wrap_neg: addr=%h valid=%b, want fffffff0 0", imem_addr, if_valid);
    end
    step(3);
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFF0 || if_inst !== 32'hC0FF_FFF0) begin
      bad++;
      $display("FAIL wrap_hi: valid=%b pc=%h inst=%h, want 1 fffffff0 c0fffff0", if_valid, if_pc, if_inst);
    end
    branch_taken = 1'b1;
    branch_imm   = 32'h10;
    step(1);
    branch_taken = 1'b0;
    total++;
    if (imem_addr !== 32'h10 || if_valid !== 1'b0) begin
      bad++;
      $display("FAIL wrap_target: addr=%h valid=%b, want 00000010 0", imem_addr, if_valid);
    end
    step(3);
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'h10 || if_inst !== 32'hC000_0010) begin
      bad++;
      $display("FAIL wrap_word: valid=%b pc=%h inst=%h, want 1 00000010 c0000010", if_valid, if_pc, if_inst);
    end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst_n        = 1'b0;
    id_ready     = 1'b1;
    branch_taken = 1'b0;
    branch_imm   = 32'h0;
    mem_lat      = 1;
    test_reset();
    test_fetch_seq();
    test_stall();
    test_redirect();
    test_redirect_rvalid();
    test_consume_load();
    test_reset_wait();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
